// File: rtl/up_down_counter_system_if.sv
// Pushbutton request lines and counter value shared between the counter and its user.
interface up_down_counter_system_if #(
  parameter int WIDTH = 16
);
  logic             u;
  logic             d;
  logic [WIDTH-1:0] c_out;

  modport master (output u, output d, input c_out);
  modport slave  (input u, input d, output c_out);
endinterface

// File: rtl/up_down_counter_system.sv
// Pushbutton up/down counter: control FSM counts once per press and stops at 0 and at all-ones.
module counter_fsm (
  input  logic clk,
  input  logic reset,
  input  logic u,
  input  logic d,
  input  logic z,
  input  logic m,
  output logic op,
  output logic c_ld,
  output logic c_clr
);
  typedef enum logic [2:0] {
    INICIO     = 3'b000,
    ESPERA     = 3'b001,
    VERIFICA   = 3'b010,
    INCREMENTA = 3'b011,
    DECREMENTA = 3'b100,
    SOLTA      = 3'b101
  } state_t;

  state_t current_state;
  state_t next_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) current_state <= INICIO;
    else        current_state <= next_state;
  end

  always_comb begin
    next_state = current_state;
    op         = 1'b0;
    c_ld       = 1'b0;
    c_clr      = 1'b0;
    case (current_state)
      INICIO: begin
        c_clr      = 1'b1;
        next_state = ESPERA;
      end
      ESPERA:   next_state = VERIFICA;
      VERIFICA: begin
        // A blocked request still goes through SOLTA so the held button cannot count later.
        if (u && !d) next_state = m ? SOLTA : INCREMENTA;
        else if (d && !u) next_state = z ? SOLTA : DECREMENTA;
      end
      INCREMENTA: begin
        c_ld       = 1'b1;
        next_state = SOLTA;
      end
      DECREMENTA: begin
        c_ld       = 1'b1;
        op         = 1'b1;
        next_state = SOLTA;
      end
      SOLTA: if (!u && !d) next_state = VERIFICA;
      default: next_state = INICIO;
    endcase
  end
endmodule

module counter_dp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op,
  input  logic             c_ld,
  input  logic             c_clr,
  output logic [WIDTH-1:0] c,
  output logic             z,
  output logic             m
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] val, input logic dn);
    return dn ? (val - ONE) : (val + ONE);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     c <= '0;
    else if (c_clr) c <= '0;
    else if (c_ld)  c <= step(c, op);
  end

  assign z = (c == '0);
  assign m = (c == '1);
endmodule

module up_down_counter_system #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  up_down_counter_system_if.slave   bus
);
  logic             op;
  logic             c_ld;
  logic             c_clr;
  logic             z;
  logic             m;
  logic [WIDTH-1:0] c;

  counter_fsm fsm (
    .clk   (clk),
    .reset (reset),
    .u     (bus.u),
    .d     (bus.d),
    .z     (z),
    .m     (m),
    .op    (op),
    .c_ld  (c_ld),
    .c_clr (c_clr)
  );

  counter_dp #(.WIDTH(WIDTH)) dp (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .c_ld  (c_ld),
    .c_clr (c_clr),
    .c     (c),
    .z     (z),
    .m     (m)
  );

  assign bus.c_out = c;
endmodule

// File: tb/tb_up_down_counter_system.sv
// Scoreboard bench for the pushbutton counter, built narrow so saturation is reachable quickly.
module tb_up_down_counter_system;
  localparam int W = 4;
  localparam logic [W-1:0] MAXV = '1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_c = '0;
  logic [W-1:0] model_c = '0;

  up_down_counter_system_if #(.WIDTH(W)) bus ();

  up_down_counter_system #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every change of c_out is one output event, matched against the queue.
  always @(negedge clk) begin
    if (mon_en && bus.c_out !== prev_c) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_change", 32'(bus.c_out), 32'(prev_c));
      end else begin
        chk("c_out_event", 32'(bus.c_out), 32'(exp_q.pop_front()));
      end
      prev_c = bus.c_out;
    end
  end

  // kind: 0 = increment, 1 = decrement, 2 = blocked, 3 = both pressed
  task automatic press(input logic pu, input logic pd, input int kind, input int hold, input int rel);
    logic [2:0] first_state;
    first_state = (kind == 0) ? 3'b011 : (kind == 1) ? 3'b100 : (kind == 2) ? 3'b101 : 3'b010;
    if (kind == 0) begin model_c = model_c + 1'b1; exp_q.push_back(model_c); end
    if (kind == 1) begin model_c = model_c - 1'b1; exp_q.push_back(model_c); end
    @(posedge clk); #1;
    bus.u = pu; bus.d = pd;
    @(posedge clk); #1;
    chk("state_after_sample", 32'(dut.fsm.current_state), 32'(first_state));
    if (kind == 1) chk("op_in_decrementa", 32'(dut.fsm.op), 32'd1);
    if (kind <= 1) chk("c_ld_in_count", 32'(dut.fsm.c_ld), 32'd1);
    repeat (hold - 1) @(posedge clk);
    #1;
    chk("state_while_held", 32'(dut.fsm.current_state), (kind == 3) ? 32'd2 : 32'd5);
    bus.u = 1'b0; bus.d = 1'b0;
    repeat (rel) @(posedge clk);
    #1;
    chk("state_after_release", 32'(dut.fsm.current_state), 32'd2);
    chk("c_out_after_press", 32'(bus.c_out), 32'(model_c));
  endtask

  task automatic do_reset(input int cycles);
    if (model_c != '0) exp_q.push_back('0);
    model_c = '0;
    reset = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.u = 1'b0;
    bus.d = 1'b0;
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    prev_c = bus.c_out;
    mon_en = 1'b1;
    chk("reset_c_out", 32'(bus.c_out), 32'd0);
    chk("reset_state", 32'(dut.fsm.current_state), 32'd2);
    chk("reset_c_ld", 32'(dut.fsm.c_ld), 32'd0);
    chk("reset_c_clr", 32'(dut.fsm.c_clr), 32'd0);
    chk("reset_z", 32'(dut.dp.z), 32'd1);

    press(1'b1, 1'b0, 0, 5, 10);
    press(1'b1, 1'b0, 0, 5, 10);
    press(1'b0, 1'b1, 1, 5, 10);

    // Reset lands while INCREMENTA is pending; the count must be lost.
    @(posedge clk); #1;
    bus.u = 1'b1;
    @(posedge clk); #1;
    chk("pending_incrementa", 32'(dut.fsm.current_state), 32'd3);
    #2;
    exp_q.push_back('0);
    model_c = '0;
    reset = 1'b0;
    #1;
    chk("async_reset_mid", 32'(bus.c_out), 32'd0);
    chk("async_reset_state", 32'(dut.fsm.current_state), 32'd0);
    bus.u = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("post_reset_c_out", 32'(bus.c_out), 32'd0);
    press(1'b0, 1'b1, 2, 5, 10);

    press(1'b1, 1'b0, 0, 5, 10);
    press(1'b1, 1'b1, 3, 5, 10);

    for (int i = 0; i < int'(MAXV) - 1; i++) press(1'b1, 1'b0, 0, 2, 2);
    chk("at_max", 32'(bus.c_out), 32'(MAXV));
    chk("m_flag", 32'(dut.dp.m), 32'd1);
    press(1'b1, 1'b0, 2, 5, 10);

    @(negedge clk); #2;
    exp_q.push_back('0);
    model_c = '0;
    reset = 1'b0;
    #1;
    chk("async_reset_max", 32'(bus.c_out), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/up_down_counter_system.md
Name: up_down_counter_system

Overview:
- Pushbutton-driven 16-bit up/down counter: a control FSM (instance `fsm`) plus a datapath register with increment/decrement and a zero/max detector (instance `dp`).
- Each press of `u` adds 1 to C; each press of `d` subtracts 1. A press holding for several cycles counts once.
- C saturates at 0 and at 2^WIDTH-1. Top-level block of the counter design; C is the only output.

Parameters:
- WIDTH, 16, counter/output width in bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- u  input  1  up request, level, synchronous to clk.
- d  input  1  down request, level, synchronous to clk.
- c_out  output  WIDTH  current counter value C.

Behaviour:
- Internal signals, kept with these names for hierarchical probing:
  - `fsm.current_state` [2:0], `fsm.op`, `fsm.c_ld`, `fsm.c_clr`.
  - `dp.z`: C==0.
  - `dp.m`: C==all ones.
- Datapath:
  - C register clears when c_clr=1.
  - Else when c_ld=1, C loads C+1 (op=0) or C-1 (op=1).
  - Else C holds. c_clr has priority over c_ld.
  - z and m are combinational from C.
- States (encoding fixed):
  - INICIO=000: c_clr=1.
  - ESPERA=001: outputs idle.
  - VERIFICA=010: outputs idle.
  - INCREMENTA=011: c_ld=1, op=0.
  - DECREMENTA=100: c_ld=1, op=1.
  - SOLTA=101: wait for release, outputs idle.
  - 110/111: go to INICIO.
- Idle outputs: c_ld=0, c_clr=0, op=0.
- Transitions, evaluated on each rising edge:
  - INICIO -> ESPERA.
  - ESPERA -> VERIFICA.
  - VERIFICA, u=1 and d=0 and m=0 -> INCREMENTA.
  - VERIFICA, d=1 and u=0 and z=0 -> DECREMENTA.
  - VERIFICA, u=1 and d=1 -> stay in VERIFICA, no count.
  - VERIFICA, request blocked by m or z -> SOLTA, no count.
  - VERIFICA, otherwise -> stay.
  - INCREMENTA -> SOLTA; DECREMENTA -> SOLTA.
  - SOLTA: stay while u|d; -> VERIFICA when u=0 and d=0.
- Reset (reset=0), asynchronous and immediate:
  - state=INICIO, C=0, c_out=0.
  - Applies mid-operation too; any pending count is lost.
- After reset release:
  - Edge 1 in INICIO clears C.
  - Edge 2 moves ESPERA->VERIFICA.
  - Ready for input from edge 3.
- Latency: request sampled in VERIFICA at edge k; state INCREMENTA/DECREMENTA during cycle k..k+1; C updated at edge k+1.
- Exactly one count per press regardless of hold length. A new press is recognised only after both inputs have been low for at least 1 cycle.
- Saturation:
  - No decrement when C=0.
  - No increment when C=2^WIDTH-1.
  - No wrap-around ever.
- Arithmetic is unsigned, WIDTH bits.

Test Plan:
- Hold reset=0 for 10 cycles, release, wait 5 cycles -> c_out=0, state=010, c_ld=0, c_clr=0.
- u=1 for 5 cycles, then u=0 for 10 cycles -> c_out=1 (single increment); state SOLTA while held, VERIFICA after release. Repeat -> c_out=2.
- From c_out=2: d=1 for 5 cycles, then 0 -> c_out=1, op=1 during the DECREMENTA cycle.
- Reset mid-count, then d=1 for 5 cycles, release -> c_out stays 0 (z blocks decrement), state returns to 010.
- From c_out=1: u=d=1 together for 5 cycles -> c_out unchanged at 1.
- Drive to 65535 (or reduce WIDTH via parameter), press u -> c_out stays 65535 (m blocks). Assert reset=0 asynchronously between clock edges -> c_out=0 immediately.
